// File: rtl/forloop_serializer_02_if.sv
// Parallel-load / serial-out bus between an upstream register bank and the serializer.
// The master drives the word and the load strobe. The slave returns the stream and its status.
interface forloop_serializer_02_if #(
  parameter int W = 32
);
  logic [W-1:0] d;
  logic         ld;
  logic         so;
  logic         sv;
  logic         busy;
  logic         done;
  logic         par;
  logic         err;

  modport master (output d, ld, input so, sv, busy, done, par, err);
  modport slave  (input d, ld, output so, sv, busy, done, par, err);
endinterface

// File: rtl/forloop_serializer_02.sv
// Captures a W-bit word on a load strobe and shifts it out one bit per clock.
// Reports the XOR parity on completion and flags loads that arrive mid-stream.
module forloop_serializer_02 #(
  parameter int W         = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                   c,
  input logic                   r,
  forloop_serializer_02_if.slave bus
);
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     shreg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             par_q, par_d;
  logic             err_q, err_d;
  logic             load_en, shift_en, so_w, last_w;

  assign so_w   = (state_q == SHIFT) & (MSB_FIRST ? shreg_q[W-1] : shreg_q[0]);
  assign last_w = (cnt_q == CNT_W'(W - 1));

  always_ff @(posedge c) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    par_d    = par_q;
    err_d    = err_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.ld) begin
          load_en = 1'b1;
          cnt_d   = '0;
          acc_d   = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        acc_d    = acc_q ^ so_w;
        cnt_d    = cnt_q + 1'b1;
        // A load while streaming is only recorded; the word in flight is untouched.
        if (bus.ld) err_d = 1'b1;
        if (last_w) begin
          state_d = DONE;
          par_d   = acc_q ^ so_w;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic shift_in;
    if (MSB_FIRST) begin : g_msb
      if (i == 0) begin : g_edge
        assign shift_in = 1'b0;
      end else begin : g_mid
        assign shift_in = shreg_q[i-1];
      end
    end else begin : g_lsb
      if (i == W - 1) begin : g_edge
        assign shift_in = 1'b0;
      end else begin : g_mid
        assign shift_in = shreg_q[i+1];
      end
    end

    always_ff @(posedge c) begin
      if (r)             shreg_q[i] <= 1'b0;
      else if (load_en)  shreg_q[i] <= bus.d[i];
      else if (shift_en) shreg_q[i] <= shift_in;
    end
  end

  assign bus.so   = so_w;
  assign bus.sv   = (state_q == SHIFT);
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.par  = par_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_forloop_serializer_02.sv
// Drives an LSB-first and an MSB-first serializer with the same stimulus.
// Each output is compared every cycle against a queue-based stream model.
module tb_forloop_serializer_02;
  localparam int W = 32;

  logic c = 1'b0;
  logic r;
  int   checks = 0;
  int   errors = 0;

  always #5 c = ~c;

  forloop_serializer_02_if #(.W(W)) bus0 ();
  forloop_serializer_02_if #(.W(W)) bus1 ();

  forloop_serializer_02 #(.W(W), .MSB_FIRST(1'b0)) dut0 (.c(c), .r(r), .bus(bus0.slave));
  forloop_serializer_02 #(.W(W), .MSB_FIRST(1'b1)) dut1 (.c(c), .r(r), .bus(bus1.slave));

  // Reference: the bits still to be sent, in emission order, for each bit order.
  bit q0[$];
  bit q1[$];
  bit m_done, m_par, m_err, m_wpar;

  function automatic void model_edge(bit rv, bit lv, logic [W-1:0] dv);
    if (rv) begin
      q0.delete();
      q1.delete();
      m_done = 1'b0;
      m_par  = 1'b0;
      m_err  = 1'b0;
    end else if (q0.size() > 0) begin
      if (lv) m_err = 1'b1;
      void'(q0.pop_front());
      void'(q1.pop_front());
      if (q0.size() == 0) begin
        m_done = 1'b1;
        m_par  = m_wpar;
      end
    end else begin
      m_done = 1'b0;
      if (lv) begin
        for (int i = 0; i < W; i++) begin
          q0.push_back(dv[i]);
          q1.push_back(dv[W-1-i]);
        end
        m_wpar = ^dv;
      end
    end
  endfunction

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    logic e_sv, e_so0, e_so1;
    e_sv  = (q0.size() > 0);
    e_so0 = e_sv ? q0[0] : 1'b0;
    e_so1 = e_sv ? q1[0] : 1'b0;
    chk("lsb_so",   bus0.so,   e_so0);
    chk("lsb_sv",   bus0.sv,   e_sv);
    chk("lsb_busy", bus0.busy, e_sv | m_done);
    chk("lsb_done", bus0.done, m_done);
    chk("lsb_par",  bus0.par,  m_par);
    chk("lsb_err",  bus0.err,  m_err);
    chk("msb_so",   bus1.so,   e_so1);
    chk("msb_sv",   bus1.sv,   e_sv);
    chk("msb_busy", bus1.busy, e_sv | m_done);
    chk("msb_done", bus1.done, m_done);
    chk("msb_par",  bus1.par,  m_par);
    chk("msb_err",  bus1.err,  m_err);
  endtask

  task automatic tick(bit rv, bit lv, logic [W-1:0] dv);
    r       = rv;
    bus0.ld = lv;
    bus1.ld = lv;
    bus0.d  = dv;
    bus1.d  = dv;
    @(negedge c);
    check_all();
    @(posedge c);
    model_edge(rv, lv, dv);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    r       = 1'b1;
    bus0.ld = 1'b0;
    bus1.ld = 1'b0;
    bus0.d  = '0;
    bus1.d  = '0;
    repeat (2) @(posedge c);
    #1;
    model_edge(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);

    // Alternating pattern, then single LSB set, then single MSB set.
    tick(1'b0, 1'b1, 32'hAAAAAAAA);
    idle(36);
    tick(1'b0, 1'b1, 32'h00000001);
    idle(36);
    tick(1'b0, 1'b1, 32'h80000000);
    idle(36);

    // Load during the fifth shift cycle: flagged, stream unaffected.
    tick(1'b0, 1'b1, 32'h12345678);
    idle(4);
    tick(1'b0, 1'b1, 32'hFFFFFFFF);
    idle(40);

    // Reset mid-stream, then a fresh full stream.
    tick(1'b0, 1'b1, 32'hDEADBEEF);
    idle(9);
    tick(1'b1, 1'b0, '0);
    idle(3);
    tick(1'b0, 1'b1, 32'hC0FFEE11);
    idle(36);

    // Reset and load together: reset wins.
    tick(1'b1, 1'b1, 32'hFFFFFFFF);
    idle(3);

    // Load held high: back-to-back streams every W+1 cycles.
    repeat (3 * (W + 1) + 2) tick(1'b0, 1'b1, 32'h0000FFFF);
    idle(3);

    // Random words, load strobes and occasional resets.
    repeat (800) tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), W'($urandom));
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
